spi_slave_byte: RTL and testbench
=================================

// Module: spi_slave_byte
// PURPOSE
// SPI responder (slave) on the far end of the SoC SPI master link. Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit words.
// Oversamples SCLK/SS_n/MOSI on the system clock.
// Hands received bytes to local logic as single-cycle strobes.
// Returns bytes from a one-entry TX holding register on MISO.
// PARAMETERS
// DATA_W       8     bits per SPI word
// SYNC_STAGES  2     synchroniser flops on SCLK, SS_n and MOSI (>=2)
// IDLE_BYTE    8'hFF word shifted out when the TX holding register is empty
// PORTS
// clk_clk        in   1       system clock (50 MHz); f_SCLK <= clk_clk/8
// reset_reset_n  in   1       asynchronous active-low reset
// spi_sclk       in   1       SPI clock from master (async)
// spi_ss_n       in   1       slave select, active low (async)
// spi_mosi       in   1       master-out data (async)
// spi_miso       out  1       slave-out data
// spi_miso_oe    out  1       MISO drive enable; top level tri-states when 0
// tx_data        in   DATA_W  next word to return to master
// tx_valid       in   1       tx_data valid
// tx_ready       out  1       holding register empty; transfer on tx_valid&&tx_ready
// rx_data        out  DATA_W  last complete received word; held until next word
// rx_valid       out  1       1-cycle strobe, rx_data updated
// tx_underrun    out  1       1-cycle strobe, IDLE_BYTE loaded (register was empty)
// frame_abort    out  1       1-cycle strobe, SS_n rose with 1..DATA_W-1 bits shifted
// BEHAVIOUR
// - Reset values: spi_miso=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_abort=0.
//   Synchroniser reset values: SS_n=1, SCLK=0. Holding register emptied; bit_cnt=0.
// - Edge detect: compare last sync stage with a delayed copy. Rise/fall each produce a one-cycle event.
// - FSM IDLE: synced SS_n=1. spi_miso_oe=0; SCLK edges ignored.
//   On SS_n fall: perform LOAD, then go to SHIFT.
// - FSM SHIFT: spi_miso_oe=1.
//   SCLK rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync}; bit_cnt++.
//   SCLK fall: tx_shift shifts left; spi_miso <= new MSB.
//   If bit_cnt==DATA_W at that fall, perform LOAD instead of shifting and set bit_cnt=0.
// - Word complete: on the DATA_W-th rise, rx_data <= assembled word. rx_valid is high in the next cycle.
//   Latency: SYNC_STAGES+2 clk_clk cycles from that SCLK pin edge. No backpressure; local logic must take the word within one word time.
// - LOAD: if the register is full, tx_shift <= register, register empties, tx_ready=1 next cycle.
//   If empty but tx_valid=1 in the same cycle, tx_data bypasses directly into tx_shift; the register stays empty.
//   Otherwise tx_shift <= IDLE_BYTE and tx_underrun pulses.
//   spi_miso <= MSB of the loaded word in the cycle after LOAD.
// - tx_ready=!full. An accept while not at LOAD fills the register; it holds until the next LOAD.
// - SS_n rise in SHIFT: return to IDLE and clear bit_cnt; discard partial rx_shift with no rx_valid.
//   frame_abort pulses iff bit_cnt was 1..DATA_W-1. The word loaded at the last LOAD is lost.
//   SS_n rise with bit_cnt==0 is a clean end.
// - SS_n rise and an SCLK edge detected in the same cycle: SS_n takes priority and the SCLK edge is dropped.
// - Reset asserted mid-frame: immediate return to reset values. After release, the block waits for a fresh SS_n fall;
//   a still-low SS_n is not treated as a frame start.
// TESTING
// - Load tx 0x3C; master sends 0xA5 (SCLK=clk/8) -> rx_data=0xA5 with one rx_valid pulse; master samples 0x3C; tx_ready=1 after SS_n fall.
// - Empty register; master sends 0x00 -> master reads 0xFF, one tx_underrun pulse, rx_data=0x00.
// - SS_n held low, 2 words; load 0x12, then 0x34 once tx_ready=1 -> master reads 0x12,0x34; two rx_valid pulses; no underrun.
// - Raise SS_n after 5 SCLK rises -> no rx_valid, one frame_abort, spi_miso_oe=0.
//   Next frame sending 0x5A -> rx_data=0x5A.
// - tx_valid=1 with 0x81 in the same cycle as the LOAD at SS_n fall -> master reads 0x81; tx_ready stays 1; no underrun.
// - Reset pulse after 3 bits with the register full -> all outputs at reset values; tx_ready=1; no rx_valid until a new SS_n fall.

Source files
------------

// File: rtl/spi_slave_byte.sv
// SPI mode-0 responder, MSB first: oversampled pins, single-cycle RX strobes, one-entry TX holding register.
// rx_valid trails the completing SCLK pin edge by SYNC_STAGES+2 cycles; RX has no backpressure, TX uses valid/ready.
module spi_slave_byte #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] IDLE_BYTE   = 8'hFF
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_sclk,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              frame_abort
);

  localparam int               CNT_W    = $clog2(DATA_W + 1);
  localparam int               SET_W    = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [SET_W-1:0] SETTLE_N = SET_W'(SYNC_STAGES);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic                   ss_dly_q, ss_dly_d;
  logic [SET_W-1:0]       settle_q, settle_d;
  logic                   armed_q, armed_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;

  // Frame control
  state_t state_q, state_d;
  logic   load, do_rise, do_fall, abort_evt;

  // Datapath
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_word;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              word_done_q, word_done_d;
  logic              rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic              underrun_q, underrun_d;
  logic              abort_q, abort_d;
  logic              tx_accept;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    ss_s        = ss_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    sclk_dly_d  = sclk_s;
    ss_dly_d    = ss_s;
    settle_d    = (settle_q == SETTLE_N) ? settle_q : settle_q + 1'b1;
    // Only a select seen high after the chains refill may open a frame, so a low SS_n at reset release is ignored.
    armed_d     = armed_q | ((settle_q == SETTLE_N) & ss_s);
  end

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q & armed_q;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
      settle_q    <= '0;
      armed_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ss_sync_q   <= ss_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_dly_q  <= sclk_dly_d;
      ss_dly_q    <= ss_dly_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ss_fall) state_d = ST_SHIFT;
      ST_SHIFT: if (ss_rise) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Select release outranks any SCLK edge detected in the same cycle.
  always_comb begin
    spi_miso_oe = 1'b0;
    load        = 1'b0;
    do_rise     = 1'b0;
    do_fall     = 1'b0;
    abort_evt   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load = ss_fall;
      end
      ST_SHIFT: begin
        spi_miso_oe = 1'b1;
        if (ss_rise) begin
          abort_evt = (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL);
        end else if (sclk_rise) begin
          do_rise = 1'b1;
        end else if (sclk_fall) begin
          if (bit_cnt_q == CNT_FULL) begin
            load = 1'b1;
          end else begin
            do_fall = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign rx_word   = {rx_shift_q, mosi_s};
  assign tx_accept = tx_valid & ~full_q;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    word_done_d = 1'b0;
    rx_valid_d  = word_done_q;
    tx_shift_d  = tx_shift_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    full_d      = full_q;
    underrun_d  = 1'b0;
    abort_d     = abort_evt;

    if (do_rise) begin
      rx_shift_d = rx_word[DATA_W-2:0];
      bit_cnt_d  = bit_cnt_q + 1'b1;
      if (bit_cnt_q == CNT_LAST) begin
        rx_data_d   = rx_word;
        word_done_d = 1'b1;
      end
    end

    if (do_fall) begin
      tx_shift_d = tx_shift_q << 1;
      miso_d     = tx_shift_q[DATA_W-2];
    end

    // An empty register with tx_valid at LOAD passes the word straight through and never fills.
    if (load) begin
      bit_cnt_d = '0;
      if (full_q) begin
        tx_shift_d = hold_q;
        full_d     = 1'b0;
      end else if (tx_valid) begin
        tx_shift_d = tx_data;
      end else begin
        tx_shift_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
      miso_d = tx_shift_d[DATA_W-1];
    end else if (tx_accept) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end

    if (state_q == ST_SHIFT && ss_rise) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      full_q      <= full_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
    end
  end

  assign spi_miso    = miso_q;
  assign tx_ready    = ~full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: bus-functional SPI master plus a queue model of the TX register and RX words.
module tb_spi_slave_byte;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic       spi_sclk, spi_ss_n, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, frame_abort;

  int errors = 0;
  int checks = 0;
  int seen_rxv = 0, seen_underrun = 0, seen_abort = 0;
  int exp_rxv = 0, exp_underrun = 0, exp_abort = 0;
  bit watch_rdy = 1'b0;
  int rdy_low = 0;

  logic [7:0] tx_model_q[$];
  logic [7:0] exp_rx_q[$];

  spi_slave_byte dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .spi_sclk     (spi_sclk),
    .spi_ss_n     (spi_ss_n),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso),
    .spi_miso_oe  (spi_miso_oe),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_underrun  (tx_underrun),
    .frame_abort  (frame_abort)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic chk_counts();
    chk("rx_valid_cnt", seen_rxv, exp_rxv);
    chk("underrun_cnt", seen_underrun, exp_underrun);
    chk("abort_cnt", seen_abort, exp_abort);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Scoreboard monitor: every rx_valid pops the oldest word the master completed.
  always @(negedge clk_clk) begin
    if (reset_reset_n) begin
      if (rx_valid) begin
        seen_rxv++;
        if (exp_rx_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: rx_valid with rx_data=%0h but no word pending", rx_data);
        end else begin
          chk("rx_data", rx_data, exp_rx_q.pop_front());
        end
      end
      if (tx_underrun) seen_underrun++;
      if (frame_abort) seen_abort++;
      if (watch_rdy && !tx_ready) rdy_low++;
    end
  end

  // Next word the slave should return: the held word, else the idle pattern with an underrun.
  function automatic logic [7:0] predict_load();
    if (tx_model_q.size() > 0) return tx_model_q.pop_front();
    exp_underrun++;
    return 8'hFF;
  endfunction

  task automatic tx_push(input logic [7:0] d);
    int w;
    w = 0;
    while (!tx_ready && w < 100) begin
      @(negedge clk_clk);
      w++;
    end
    chk("tx_ready_wait", tx_ready, 1);
    if (tx_ready) begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge clk_clk);
      #1;
      tx_valid = 1'b0;
      tx_model_q.push_back(d);
    end
  endtask

  // One word, MSB first, SCLK = clk/8. cut>0 stops after that many rises with SCLK left high.
  // On the last word of a frame the final fall is left to the caller, which pairs it with SS_n rising.
  task automatic spi_word(input logic [7:0] mo, input bit last, input int cut,
                          input bit do_push, input logic [7:0] pv, output logic [7:0] mi);
    mi = '0;
    for (int b = 7; b >= 0; b--) begin
      spi_mosi = mo[b];
      cyc(4);
      mi = {mi[6:0], spi_miso};
      spi_sclk = 1'b1;
      if (b == 0) begin
        exp_rx_q.push_back(mo);
        exp_rxv++;
      end
      if (cut == 8 - b) return;
      if (b == 7 && do_push) tx_push(pv);
      cyc(4);
      if (b > 0 || !last) spi_sclk = 1'b0;
    end
  endtask

  // push_mode: 0 none, 1 push pv during the first word, 2 random pushes whenever the register is empty.
  task automatic spi_frame(input int nw, input logic [7:0] w0, input int cut,
                           input int push_mode, input logic [7:0] pv, input bit bypass);
    logic [7:0] mo, mi, ex;
    bit dp;
    @(negedge clk_clk);
    spi_ss_n = 1'b0;
    ex = pv;
    if (bypass) begin
      // Present tx_data exactly in the cycle the synchronised SS_n fall is seen.
      @(posedge clk_clk);
      @(posedge clk_clk);
      #1;
      tx_data  = pv;
      tx_valid = 1'b1;
      @(posedge clk_clk);
      #1;
      tx_valid = 1'b0;
    end
    for (int w = 0; w < nw; w++) begin
      if (!(bypass && w == 0)) ex = predict_load();
      mo = (w == 0) ? w0 : 8'($urandom);
      dp = ((push_mode == 1 && w == 0) ||
            (push_mode == 2 && $urandom_range(0, 1) == 1)) && tx_model_q.size() == 0;
      spi_word(mo, w == nw - 1, (w == nw - 1) ? cut : 0, dp,
               (push_mode == 2) ? 8'($urandom) : pv, mi);
      if (w == nw - 1 && cut > 0) chk("miso_partial", mi, ex >> (8 - cut));
      else chk("miso_word", mi, ex);
      if (w == 0) chk("miso_oe_on", spi_miso_oe, 1);
    end
    if (cut > 0) begin
      cyc(4);
      exp_abort++;
    end
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    cyc(8);
    chk("miso_oe_off", spi_miso_oe, 0);
  endtask

  initial begin
    logic [7:0] mo, mi, ex;
    reset_reset_n = 1'b0;
    spi_sclk = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    tx_data  = '0;
    tx_valid = 1'b0;
    cyc(3);
    chk("rst_miso", spi_miso, 0);
    chk("rst_miso_oe", spi_miso_oe, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_underrun", tx_underrun, 0);
    chk("rst_abort", frame_abort, 0);
    reset_reset_n = 1'b1;
    cyc(10);

    // Preloaded word returned while 0xA5 arrives
    tx_push(8'h3C);
    chk("t1_ready_full", tx_ready, 0);
    spi_frame(1, 8'hA5, 0, 0, 8'h00, 1'b0);
    chk("t1_rx_data", rx_data, 8'hA5);
    chk("t1_tx_ready", tx_ready, 1);
    chk_counts();

    // Empty register returns the idle pattern
    spi_frame(1, 8'h00, 0, 0, 8'h00, 1'b0);
    chk("t2_rx_data", rx_data, 8'h00);
    chk("t2_underrun", seen_underrun, 1);
    chk_counts();

    // Two words in one frame, second word supplied during the first
    tx_push(8'h12);
    spi_frame(2, 8'h6E, 0, 1, 8'h34, 1'b0);
    chk("t3_underrun", seen_underrun, 1);
    chk_counts();

    // Abort after 5 rises, then a clean frame
    spi_frame(1, 8'hC7, 5, 0, 8'h00, 1'b0);
    chk("t4_abort", seen_abort, 1);
    chk_counts();
    spi_frame(1, 8'h5A, 0, 0, 8'h00, 1'b0);
    chk("t4_rx_data", rx_data, 8'h5A);
    chk_counts();

    // Bypass at the frame-start LOAD
    watch_rdy = 1'b1;
    spi_frame(1, 8'h3E, 0, 0, 8'h81, 1'b1);
    watch_rdy = 1'b0;
    chk("t5_ready_low_cycles", rdy_low, 0);
    chk("t5_tx_ready", tx_ready, 1);
    chk_counts();

    // Reset mid-frame with the register full
    tx_push(8'h5C);
    @(negedge clk_clk);
    spi_ss_n = 1'b0;
    ex = predict_load();
    mo = 8'($urandom);
    spi_word(mo, 1'b1, 3, 1'b1, 8'hC3, mi);
    chk("t6_miso_3bits", mi, ex >> 5);
    cyc(3);
    chk("t6_ready_full", tx_ready, 0);
    reset_reset_n = 1'b0;
    #1;
    chk("t6_miso", spi_miso, 0);
    chk("t6_miso_oe", spi_miso_oe, 0);
    chk("t6_tx_ready", tx_ready, 1);
    chk("t6_rx_data", rx_data, 0);
    chk("t6_rx_valid", rx_valid, 0);
    chk("t6_underrun", tx_underrun, 0);
    chk("t6_abort", frame_abort, 0);
    tx_model_q.delete();
    cyc(3);
    reset_reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(4);
      spi_sclk = 1'b0;
      spi_mosi = 1'($urandom);
      cyc(4);
      spi_sclk = 1'b1;
    end
    cyc(4);
    spi_sclk = 1'b0;
    chk("t6_oe_stays_off", spi_miso_oe, 0);
    cyc(2);
    spi_ss_n = 1'b1;
    cyc(8);
    chk("t6_rx_data_after", rx_data, 0);
    chk("t6_ready_after", tx_ready, 1);
    chk_counts();
    spi_frame(1, 8'h5A, 0, 0, 8'h00, 1'b0);
    chk("t6_next_rx", rx_data, 8'h5A);
    chk_counts();

    // Randomised frames: word counts, aborts and TX refills
    for (int f = 0; f < 24; f++) begin
      int nw;
      int cut;
      nw  = $urandom_range(1, 3);
      cut = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
      if (tx_model_q.size() == 0 && $urandom_range(0, 1) == 1) tx_push(8'($urandom));
      spi_frame(nw, 8'($urandom), cut, 2, 8'h00, 1'b0);
      chk_counts();
    end

    cyc(20);
    chk("rx_queue_drained", exp_rx_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
